// File: rtl/imm_splitter_if.sv
// Handshake bundle between the load-constant expander, imm_splitter and the instruction formatter.
// Latency: none (wires only).
// Backpressure: valid/ready on both the constant input side and the immediate output side.
interface imm_splitter_if #(
  parameter int IN_WIDTH  = 16,
  parameter int IMM_WIDTH = 11
);
  logic [IN_WIDTH-1:0]  in_value;
  logic                 in_valid;
  logic                 in_ready;
  logic [IMM_WIDTH-1:0] out_imm;
  logic [1:0]           out_kind;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  // Producer of constants and consumer of beats.
  modport master (
    output in_value, in_valid, out_ready,
    input  in_ready, out_imm, out_kind, out_last, out_valid
  );

  // The splitter itself.
  modport slave (
    input  in_value, in_valid, out_ready,
    output in_ready, out_imm, out_kind, out_last, out_valid
  );
endinterface

// File: rtl/imm_splitter.sv
// Splits a constant into one SINGLE beat (fits signed IMM_WIDTH) or UPPER then LOWER beats.
// Latency: first beat is valid one cycle after the input handshake; all beat outputs are registered.
// Backpressure: beats hold while out_ready is low; in_ready is high only when idle.
module imm_splitter #(
  parameter int IN_WIDTH  = 16,
  parameter int IMM_WIDTH = 11
) (
  input logic          CLK,
  input logic          Reset,
  imm_splitter_if.slave bus
);
  localparam int LO_WIDTH = IN_WIDTH - IMM_WIDTH;

  localparam logic [1:0] KIND_SINGLE = 2'b00;
  localparam logic [1:0] KIND_UPPER  = 2'b01;
  localparam logic [1:0] KIND_LOWER  = 2'b10;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    EMIT_SINGLE = 2'd1,
    EMIT_UPPER  = 2'd2,
    EMIT_LOWER  = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [IMM_WIDTH-1:0] imm_q, imm_n;
  logic [1:0]           kind_q, kind_n;
  logic                 last_q, last_n;
  logic                 valid_q, valid_n;
  logic [LO_WIDTH-1:0]  lo_q, lo_n;

  // Bits that must all equal the immediate's sign bit for sign extension to be exact.
  logic [LO_WIDTH:0]    hi_bits;
  logic                 fits;

  assign hi_bits = bus.in_value[IN_WIDTH-1:IMM_WIDTH-1];
  assign fits    = (&hi_bits) | ~(|hi_bits);

  // State and registered beat outputs; reset drops any pending beat.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      imm_q   <= '0;
      kind_q  <= KIND_SINGLE;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      lo_q    <= '0;
    end else begin
      state   <= state_n;
      imm_q   <= imm_n;
      kind_q  <= kind_n;
      last_q  <= last_n;
      valid_q <= valid_n;
      lo_q    <= lo_n;
    end
  end

  // Next state and next beat contents; outputs return to zero whenever no beat is pending.
  always_comb begin
    state_n = state;
    imm_n   = imm_q;
    kind_n  = kind_q;
    last_n  = last_q;
    valid_n = valid_q;
    lo_n    = lo_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          valid_n = 1'b1;
          if (fits) begin
            state_n = EMIT_SINGLE;
            imm_n   = bus.in_value[IMM_WIDTH-1:0];
            kind_n  = KIND_SINGLE;
            last_n  = 1'b1;
          end else begin
            state_n = EMIT_UPPER;
            imm_n   = bus.in_value[IN_WIDTH-1:LO_WIDTH];
            kind_n  = KIND_UPPER;
            last_n  = 1'b0;
            lo_n    = bus.in_value[LO_WIDTH-1:0];
          end
        end
      end
      EMIT_UPPER: begin
        if (bus.out_ready) begin
          state_n = EMIT_LOWER;
          imm_n   = IMM_WIDTH'(lo_q);
          kind_n  = KIND_LOWER;
          last_n  = 1'b1;
        end
      end
      EMIT_SINGLE, EMIT_LOWER: begin
        if (bus.out_ready) begin
          state_n = IDLE;
          imm_n   = '0;
          kind_n  = KIND_SINGLE;
          last_n  = 1'b0;
          valid_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        imm_n   = '0;
        kind_n  = KIND_SINGLE;
        last_n  = 1'b0;
        valid_n = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_imm   = imm_q;
  assign bus.out_kind  = kind_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_imm_splitter.sv
// Self-checking bench for imm_splitter: directed boundary cases, backpressure, mid-split reset,
// and a randomized sweep whose scoreboard rebuilds every constant from its beats.
// Expected beats come from a signed-range model of the splitting rules.
module tb_imm_splitter;
  logic CLK;
  logic Reset;

  imm_splitter_if #(.IN_WIDTH(16), .IMM_WIDTH(11)) bus ();

  imm_splitter #(.IN_WIDTH(16), .IMM_WIDTH(11)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Reference model: signed range test, then fixed shift/mask split.
  function automatic bit model_fits(input logic [15:0] v);
    int sv;
    sv = int'($signed(v));
    return (sv >= -1024) && (sv <= 1023);
  endfunction

  function automatic int model_nbeats(input logic [15:0] v);
    return model_fits(v) ? 1 : 2;
  endfunction

  function automatic logic [10:0] model_imm(input logic [15:0] v, input int b);
    int uv;
    uv = int'(v);
    if (model_fits(v)) return 11'(uv % 2048);
    if (b == 0) return 11'(uv / 32);
    return 11'(uv % 32);
  endfunction

  function automatic logic [1:0] model_kind(input logic [15:0] v, input int b);
    if (model_fits(v)) return 2'b00;
    return (b == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_vld"},  32'(bus.out_valid), 32'd0);
    check({tag, "_imm"},  32'(bus.out_imm),   32'd0);
    check({tag, "_kind"}, 32'(bus.out_kind),  32'd0);
    check({tag, "_last"}, 32'(bus.out_last),  32'd0);
    check({tag, "_rdy"},  32'(bus.in_ready),  32'd1);
  endtask

  // Sends one constant with out_ready high and checks each beat against the model.
  task automatic run_const(input logic [15:0] v);
    int nb;
    nb = model_nbeats(v);
    check("pre_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_value  = v;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      check($sformatf("beat_vld_%04h_%0d", v, b),  32'(bus.out_valid), 32'd1);
      check($sformatf("beat_imm_%04h_%0d", v, b),  32'(bus.out_imm),   32'(model_imm(v, b)));
      check($sformatf("beat_kind_%04h_%0d", v, b), 32'(bus.out_kind),  32'(model_kind(v, b)));
      check($sformatf("beat_last_%04h_%0d", v, b), 32'(bus.out_last),  32'(b == nb - 1));
      check($sformatf("beat_rdy_%04h_%0d", v, b),  32'(bus.in_ready),  32'd0);
      tick();
    end
    check_idle($sformatf("after_%04h", v));
  endtask

  logic [15:0] sweep_q[$];
  logic [10:0] upper_imm;
  bit          have_upper;
  int          sent;
  int          received;
  bit          accepted;
  logic [15:0] rebuilt;
  logic [15:0] expv;

  localparam int N_SWEEP = 300;

  initial begin
    bus.in_value  = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    Reset         = 1'b1;
    #3;
    check_idle("reset");
    Reset = 1'b0;
    tick();
    check_idle("post_reset");

    // Directed boundary constants.
    run_const(16'h03FF);
    run_const(16'hFC00);
    run_const(16'hFFFF);
    run_const(16'h0000);
    run_const(16'h0400);
    run_const(16'hFBFF);
    run_const(16'hABCD);

    // Backpressure on both beats, with stray in_valid pulses that must be ignored.
    bus.in_value  = 16'hABCD;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = (i != 1);
      bus.in_value = 16'h1111 + 16'(i);
      check("bp_up_vld",  32'(bus.out_valid), 32'd1);
      check("bp_up_imm",  32'(bus.out_imm),   32'h55E);
      check("bp_up_kind", 32'(bus.out_kind),  32'd1);
      check("bp_up_last", 32'(bus.out_last),  32'd0);
      check("bp_up_rdy",  32'(bus.in_ready),  32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = (i != 0);
      bus.in_value = 16'h0007;
      check("bp_lo_vld",  32'(bus.out_valid), 32'd1);
      check("bp_lo_imm",  32'(bus.out_imm),   32'h00D);
      check("bp_lo_kind", 32'(bus.out_kind),  32'd2);
      check("bp_lo_last", 32'(bus.out_last),  32'd1);
      check("bp_lo_rdy",  32'(bus.in_ready),  32'd0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check_idle("bp_done");
    tick();
    check_idle("bp_nocapture");

    // Reset between UPPER and LOWER discards the LOWER beat.
    bus.in_value  = 16'h1234;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("rst_up_imm",  32'(bus.out_imm),  32'h091);
    check("rst_up_kind", 32'(bus.out_kind), 32'd1);
    #1 Reset = 1'b1;
    #1;
    check_idle("rst_async");
    bus.out_ready = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    check_idle("rst_no_lower");
    run_const(16'h0005);

    // Randomized sweep with random backpressure; rebuild every constant from its beats.
    sent       = 0;
    received   = 0;
    have_upper = 1'b0;
    for (int cyc = 0; cyc < 20000 && received < N_SWEEP; cyc++) begin
      if (!bus.in_valid && sent < N_SWEEP && ($urandom % 4) != 0) begin
        case ($urandom % 4)
          0:       bus.in_value = 16'($urandom_range(0, 2047)) - 16'd1024;
          1:       bus.in_value = 16'($urandom_range(0, 63)) + 16'h03E0;
          default: bus.in_value = 16'($urandom);
        endcase
        bus.in_valid = 1'b1;
      end
      bus.out_ready = (($urandom % 4) != 0);
      if (bus.out_valid) begin
        check("kind_legal", 32'(bus.out_kind == 2'b11), 32'd0);
        if (bus.out_ready) begin
          if (bus.out_kind == 2'b01) begin
            check("sw_upper_last", 32'(bus.out_last), 32'd0);
            check("sw_upper_dup", 32'(have_upper), 32'd0);
            upper_imm  = bus.out_imm;
            have_upper = 1'b1;
          end else begin
            check("sw_last", 32'(bus.out_last), 32'd1);
            if (bus.out_kind == 2'b10) begin
              check("sw_lower_hi0", 32'(bus.out_imm[10:5]), 32'd0);
              check("sw_lower_has_upper", 32'(have_upper), 32'd1);
              rebuilt = 16'({5'd0, upper_imm} << 5) | {11'd0, bus.out_imm[4:0]};
            end else begin
              check("sw_single_no_upper", 32'(have_upper), 32'd0);
              rebuilt = {{5{bus.out_imm[10]}}, bus.out_imm};
            end
            have_upper = 1'b0;
            if (sweep_q.size() == 0) begin
              check("sw_unexpected_beat", 32'(rebuilt), 32'hDEAD_BEEF);
            end else begin
              expv = sweep_q.pop_front();
              check($sformatf("sw_value_%0d", received), 32'(rebuilt), 32'(expv));
              check($sformatf("sw_split_%0d", received), 32'(bus.out_kind == 2'b10),
                    32'(!model_fits(expv)));
            end
            received++;
          end
        end
      end
      accepted = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        sweep_q.push_back(bus.in_value);
        sent++;
        accepted = 1'b1;
      end
      tick();
      if (accepted) bus.in_valid = 1'b0;
    end
    check("sweep_complete", 32'(received), 32'(N_SWEEP));
    check("sweep_queue_empty", 32'(sweep_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
